// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared constants and types for the instruction-fetch stage.
//   NOP_INSTR - encoding used for pipeline bubbles
//   PC_STEP   - sequential PC increment
//   fetch_state_e - redirect state of the fetch stage
package if_stage_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic {
    ST_RUN              = 1'b0,
    ST_REDIRECT_PENDING = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: bus between the fetch stage and its surroundings
// (instruction memory, decode control unit, decode stage).
//   master - the fetch stage side
//   slave  - memory / control unit / decode side
interface if_stage_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_instr;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic        id_valid;

  modport master (
    output imem_addr, if_instr, id_instr, id_pc4, id_valid,
    input  imem_data, stall, branch_taken, branch_target
  );

  modport slave (
    input  imem_addr, if_instr, id_instr, id_pc4, id_valid,
    output imem_data, stall, branch_taken, branch_target
  );

endinterface

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
//   clk, rst  - clock, async active-low reset
//   bubble    - 1: load a NOP and clear valid, keep pc4; 0: load instr/pc4
//   instr     - instruction fetched this cycle
//   pc4       - PC+4 of that instruction
//   id_instr, id_pc4, id_valid - registered outputs towards decode
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        bubble,
  input  logic [31:0] instr,
  input  logic [31:0] pc4,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic        id_valid
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_instr <= NOP_INSTR;
      id_pc4   <= 32'h0;
      id_valid <= 1'b0;
    end else if (bubble) begin
      // id_pc4 deliberately holds across a bubble
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
    end else begin
      id_instr <= instr;
      id_pc4   <= pc4;
      id_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage with IF/ID register.
//   clk, rst  - clock, async active-low reset
//   bus       - if_stage_if.master: imem address/data, if_instr, stall and
//               branch inputs from decode, IF/ID outputs
//   stall_cnt - saturating count of cycles with stall=1
//   flush_cnt - saturating count of bubbles caused by branch flush
//
// state               | meaning
// --------------------+------------------------------------------------------
// ST_RUN              | normal fetch, no redirect outstanding
// ST_REDIRECT_PENDING | taken branch seen during stall (DELAY_SLOT=1); the
//                     | delay slot waits in IF, target applied when stall drops
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          DELAY_SLOT = 0,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  if_stage_if.master       bus,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d, pc_plus4;
  logic [31:0]  pend_target_q, pend_target_d;
  logic         pend_valid;
  logic         bubble;
  logic         flush;

  assign pc_plus4     = pc_q + PC_STEP;
  assign pend_valid   = (state_q == ST_REDIRECT_PENDING);
  assign bus.imem_addr = pc_q;
  assign bus.if_instr  = bus.imem_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      pend_target_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pend_target_d = pend_target_q;
    pc_d          = pc_plus4;
    bubble        = 1'b0;
    flush         = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.branch_taken && DELAY_SLOT == 0) begin
          // the fall-through instruction in IF is squashed
          pc_d   = bus.branch_target;
          bubble = 1'b1;
          flush  = 1'b1;
        end else if (bus.branch_taken && bus.stall) begin
          // delay slot is stalled in IF; remember where to go afterwards
          state_d       = ST_REDIRECT_PENDING;
          pend_target_d = bus.branch_target;
          pc_d          = pc_q;
          bubble        = 1'b1;
        end else if (bus.branch_taken) begin
          pc_d = bus.branch_target;
        end else if (bus.stall) begin
          pc_d   = pc_q;
          bubble = 1'b1;
        end
      end
      ST_REDIRECT_PENDING: begin
        // a new branch cannot be in ID here; the pending target always wins
        if (bus.stall) begin
          pc_d   = pc_q;
          bubble = 1'b1;
        end else begin
          pc_d    = pend_target_q;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .bubble   (bubble),
    .instr    (bus.imem_data),
    .pc4      (pc_plus4),
    .id_instr (bus.id_instr),
    .id_pc4   (bus.id_pc4),
    .id_valid (bus.id_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bus.stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (flush && flush_cnt != '1)     flush_cnt <= flush_cnt + 1'b1;
    end
  end

  a_no_branch_while_pending : assert property (
    @(posedge clk) disable iff (!rst) !(pend_valid && bus.branch_taken)
  );

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed bench for if_stage.
//   dut_a: DELAY_SLOT=0, CNT_W=4 (flush path, wrap, counter saturation)
//   dut_b: DELAY_SLOT=1, CNT_W=16 (delay slot, pending redirect, async reset)
module tb_if_stage;

  logic clk;
  logic rst_a, rst_b;
  logic [3:0]  stall_cnt_a, flush_cnt_a;
  logic [15:0] stall_cnt_b, flush_cnt_b;
  int checks = 0;
  int errors = 0;

  if_stage_if bus_a ();
  if_stage_if bus_b ();

  function automatic logic [31:0] imem_f(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  assign bus_a.imem_data = imem_f(bus_a.imem_addr);
  assign bus_b.imem_data = imem_f(bus_b.imem_addr);

  if_stage #(.RESET_PC(32'h0), .DELAY_SLOT(0), .CNT_W(4)) dut_a (
    .clk       (clk),
    .rst       (rst_a),
    .bus       (bus_a),
    .stall_cnt (stall_cnt_a),
    .flush_cnt (flush_cnt_a)
  );

  if_stage #(.RESET_PC(32'h0), .DELAY_SLOT(1), .CNT_W(16)) dut_b (
    .clk       (clk),
    .rst       (rst_b),
    .bus       (bus_b),
    .stall_cnt (stall_cnt_b),
    .flush_cnt (flush_cnt_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    bus_a.stall = 1'b0; bus_a.branch_taken = 1'b0; bus_a.branch_target = 32'h0;
    bus_b.stall = 1'b0; bus_b.branch_taken = 1'b0; bus_b.branch_target = 32'h0;

    // ---------------- dut_a : DELAY_SLOT=0 ----------------
    tick();
    check("a_rst_pc",       bus_a.imem_addr, 32'h0);
    check("a_rst_instr",    bus_a.id_instr, 32'h0);
    check("a_rst_pc4",      bus_a.id_pc4, 32'h0);
    check("a_rst_valid",    {31'b0, bus_a.id_valid}, 32'h0);
    check("a_rst_stallcnt", {28'b0, stall_cnt_a}, 32'h0);
    check("a_rst_flushcnt", {28'b0, flush_cnt_a}, 32'h0);
    check("a_if_instr",     bus_a.if_instr, 32'hA5A5_0000);
    #2 rst_a = 1'b1;

    for (int i = 1; i <= 4; i++) begin
      tick();
      check("a_seq_pc",    bus_a.imem_addr, 32'(4 * i));
      check("a_seq_instr", bus_a.id_instr, imem_f(32'(4 * (i - 1))));
      check("a_seq_pc4",   bus_a.id_pc4, 32'(4 * i));
      check("a_seq_valid", {31'b0, bus_a.id_valid}, 32'h1);
    end

    bus_a.stall = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      tick();
      check("a_stall_pc",    bus_a.imem_addr, 32'h10);
      check("a_stall_instr", bus_a.id_instr, 32'h0);
      check("a_stall_valid", {31'b0, bus_a.id_valid}, 32'h0);
      check("a_stall_pc4",   bus_a.id_pc4, 32'h10);
      check("a_stall_cnt",   {28'b0, stall_cnt_a}, 32'(i));
    end
    bus_a.stall = 1'b0;
    tick();
    check("a_unstall_pc",    bus_a.imem_addr, 32'h14);
    check("a_unstall_instr", bus_a.id_instr, imem_f(32'h10));
    check("a_unstall_pc4",   bus_a.id_pc4, 32'h14);
    check("a_unstall_valid", {31'b0, bus_a.id_valid}, 32'h1);
    tick();
    tick();
    check("a_pre_br_pc", bus_a.imem_addr, 32'h1C);

    // taken branch with stall also high: flush wins, stall still counted
    bus_a.branch_taken = 1'b1; bus_a.branch_target = 32'h40; bus_a.stall = 1'b1;
    tick();
    check("a_br_pc",       bus_a.imem_addr, 32'h40);
    check("a_br_valid",    {31'b0, bus_a.id_valid}, 32'h0);
    check("a_br_instr",    bus_a.id_instr, 32'h0);
    check("a_br_pc4",      bus_a.id_pc4, 32'h1C);
    check("a_br_flushcnt", {28'b0, flush_cnt_a}, 32'h1);
    check("a_br_stallcnt", {28'b0, stall_cnt_a}, 32'h3);
    bus_a.branch_taken = 1'b0; bus_a.stall = 1'b0;
    tick();
    check("a_tgt_instr", bus_a.id_instr, imem_f(32'h40));
    check("a_tgt_pc4",   bus_a.id_pc4, 32'h44);
    check("a_tgt_pc",    bus_a.imem_addr, 32'h44);

    bus_a.branch_taken = 1'b1; bus_a.branch_target = 32'hFFFF_FFFC;
    tick();
    check("a_top_pc",      bus_a.imem_addr, 32'hFFFF_FFFC);
    check("a_top_flushcnt", {28'b0, flush_cnt_a}, 32'h2);
    bus_a.branch_taken = 1'b0;
    tick();
    check("a_wrap_pc",    bus_a.imem_addr, 32'h0);
    check("a_wrap_pc4",   bus_a.id_pc4, 32'h0);
    check("a_wrap_instr", bus_a.id_instr, imem_f(32'hFFFF_FFFC));
    check("a_wrap_valid", {31'b0, bus_a.id_valid}, 32'h1);

    // 2^4+3 stall cycles starting from stall_cnt=3
    bus_a.stall = 1'b1;
    repeat (12) tick();
    check("a_sat_reach", {28'b0, stall_cnt_a}, 32'hF);
    repeat (7) tick();
    check("a_sat_hold",  {28'b0, stall_cnt_a}, 32'hF);
    check("a_sat_pc",    bus_a.imem_addr, 32'h0);
    bus_a.stall = 1'b0;

    // ---------------- dut_b : DELAY_SLOT=1 ----------------
    rst_a = 1'b0;
    check("b_rst_pc", bus_b.imem_addr, 32'h0);
    rst_b = 1'b1;
    repeat (8) tick();
    check("b_pre_pc",    bus_b.imem_addr, 32'h20);
    check("b_pre_instr", bus_b.id_instr, imem_f(32'h1C));

    bus_b.branch_taken = 1'b1; bus_b.branch_target = 32'h80; bus_b.stall = 1'b1;
    tick();
    check("b_pend_pc",    bus_b.imem_addr, 32'h20);
    check("b_pend_flag",  {31'b0, dut_b.pend_valid}, 32'h1);
    check("b_pend_valid", {31'b0, bus_b.id_valid}, 32'h0);
    check("b_pend_instr", bus_b.id_instr, 32'h0);
    bus_b.branch_taken = 1'b0;
    tick();
    check("b_pend2_pc",   bus_b.imem_addr, 32'h20);
    check("b_pend2_flag", {31'b0, dut_b.pend_valid}, 32'h1);
    check("b_pend2_cnt",  {16'b0, stall_cnt_b}, 32'h2);
    bus_b.stall = 1'b0;
    tick();
    check("b_slot_instr", bus_b.id_instr, imem_f(32'h20));
    check("b_slot_pc4",   bus_b.id_pc4, 32'h24);
    check("b_slot_pc",    bus_b.imem_addr, 32'h80);
    check("b_slot_flag",  {31'b0, dut_b.pend_valid}, 32'h0);
    check("b_slot_valid", {31'b0, bus_b.id_valid}, 32'h1);
    tick();
    check("b_tgt_instr", bus_b.id_instr, imem_f(32'h80));
    check("b_tgt_pc",    bus_b.imem_addr, 32'h84);

    // taken branch without stall: delay slot proceeds, no flush
    bus_b.branch_taken = 1'b1; bus_b.branch_target = 32'h100;
    tick();
    check("b_ds_pc",       bus_b.imem_addr, 32'h100);
    check("b_ds_instr",    bus_b.id_instr, imem_f(32'h84));
    check("b_ds_pc4",      bus_b.id_pc4, 32'h88);
    check("b_ds_flushcnt", {16'b0, flush_cnt_b}, 32'h0);

    // pending redirect killed by asynchronous reset
    bus_b.branch_target = 32'h200; bus_b.stall = 1'b1;
    tick();
    bus_b.branch_taken = 1'b0;
    check("b_pend3_flag", {31'b0, dut_b.pend_valid}, 32'h1);
    check("b_pend3_pc",   bus_b.imem_addr, 32'h100);
    #3 rst_b = 1'b0;
    #1;
    check("b_arst_pc",       bus_b.imem_addr, 32'h0);
    check("b_arst_flag",     {31'b0, dut_b.pend_valid}, 32'h0);
    check("b_arst_valid",    {31'b0, bus_b.id_valid}, 32'h0);
    check("b_arst_pc4",      bus_b.id_pc4, 32'h0);
    check("b_arst_instr",    bus_b.id_instr, 32'h0);
    check("b_arst_stallcnt", {16'b0, stall_cnt_b}, 32'h0);
    #2;
    bus_b.stall = 1'b0;
    rst_b = 1'b1;
    tick();
    check("b_post_pc",    bus_b.imem_addr, 32'h4);
    check("b_post_flag",  {31'b0, dut_b.pend_valid}, 32'h0);
    check("b_post_instr", bus_b.id_instr, imem_f(32'h0));
    check("b_post_valid", {31'b0, bus_b.id_valid}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
